// File: rtl/rep_stream_arb.sv
// Packet-level round-robin merge of N_SRC beat streams onto one registered output.
// A grant is held for a whole packet; a beat watchdog cuts runaway packets at MAX_LEN.
module rep_stream_arb #(
  parameter int DATA_W  = 8,
  parameter int N_SRC   = 4,
  parameter int MAX_LEN = 16
) (
  input  logic                    clk_i,
  input  logic                    nrst_i,
  input  logic [N_SRC-1:0]        snk_vd_i,
  input  logic [N_SRC*DATA_W-1:0] snk_data_i,
  input  logic [N_SRC-1:0]        snk_sop_i,
  input  logic [N_SRC-1:0]        snk_eop_i,
  output logic [N_SRC-1:0]        snk_rdy_o,
  input  logic                    src_rdy_i,
  output logic [DATA_W-1:0]       src_data_o,
  output logic                    src_sop_o,
  output logic                    src_eop_o,
  output logic                    src_vd_o,
  output logic [N_SRC-1:0]        grant_o,
  output logic                    err_o
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [N_SRC-1:0]  grant_q;
  logic [IW-1:0]     last_q;
  logic [7:0]        cnt_q;

  logic [IW-1:0]     pick_idx, g_idx;
  logic              found;
  logic [DATA_W-1:0] g_data;
  logic              g_vd, g_sop, g_eop;
  logic              out_free, snk_hs, first_beat, last_beat, cut, end_pkt, sop_err;

  // Round-robin search starting just above the previous packet's owner
  always_comb begin
    pick_idx = last_q;
    found    = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      int j;
      j = (int'(last_q) + i) % N_SRC;
      if (!found && snk_vd_i[IW'(j)]) begin
        found    = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  always_comb begin
    g_idx  = '0;
    g_data = '0;
    g_vd   = 1'b0;
    g_sop  = 1'b0;
    g_eop  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) begin
        g_idx  = IW'(i);
        g_data = snk_data_i[i*DATA_W +: DATA_W];
        g_vd   = snk_vd_i[i];
        g_sop  = snk_sop_i[i];
        g_eop  = snk_eop_i[i];
      end
    end
  end

  // Output slot is free when empty or being drained this cycle
  assign out_free   = !src_vd_o || src_rdy_i;
  assign snk_rdy_o  = (state == LOCK) ? (grant_q & {N_SRC{out_free}}) : '0;
  assign snk_hs     = (state == LOCK) && g_vd && out_free;
  assign first_beat = (cnt_q == 8'd0);
  assign last_beat  = (cnt_q == 8'(MAX_LEN - 1));
  assign cut        = last_beat && !g_eop;
  assign end_pkt    = g_eop || last_beat;
  assign sop_err    = first_beat ? !g_sop : g_sop;
  assign grant_o    = grant_q;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(N_SRC - 1);
      cnt_q      <= 8'd0;
      src_data_o <= '0;
      src_sop_o  <= 1'b0;
      src_eop_o  <= 1'b0;
      src_vd_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      // sop/eop are regenerated from packet position, not passed through
      if (snk_hs) begin
        src_data_o <= g_data;
        src_sop_o  <= first_beat;
        src_eop_o  <= end_pkt;
        src_vd_o   <= 1'b1;
      end else if (src_vd_o && src_rdy_i) begin
        src_vd_o   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|snk_vd_i) begin
            grant_q <= N_SRC'(1) << pick_idx;
            cnt_q   <= 8'd0;
            state   <= LOCK;
          end
        end
        LOCK: begin
          if (snk_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (sop_err || cut) err_o <= 1'b1;
            if (end_pkt) begin
              last_q  <= g_idx;
              grant_q <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
